// File: rtl/range_uart_tx.sv
// Serialises a 10-bit range plus error flag as a two-byte 8N1 UART report.
// Byte0 = {1, err, 0000, range[9:8]}, byte1 = range[7:0].
module range_uart_tx #(
  parameter int WIDTH        = 10,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] range,
  input  logic             debug_error,
  input  logic             send,
  output logic             tx,
  output logic             busy,
  output logic             overrun
);

  // state | meaning
  // IDLE  | line high, waiting for send
  // START | start bit (0) of current byte
  // DATA  | data bit bit_cnt of current byte, LSB first
  // STOP  | stop bit (1); byte_idx picks next byte or IDLE
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_TC = CW'(CLKS_PER_BIT - 1);

  state_t           state, state_n;
  logic [CW-1:0]    baud_cnt, baud_cnt_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic             byte_idx, byte_idx_n;
  logic [WIDTH-1:0] range_q;
  logic             err_q;
  logic             baud_tc;
  logic             accept;
  logic [7:0]       cur_byte;

  assign baud_tc  = (baud_cnt == BAUD_TC);
  assign accept   = (state == IDLE) && send;
  assign cur_byte = byte_idx ? range_q[7:0] : {1'b1, err_q, 4'b0000, range_q[9:8]};

  always_comb begin
    state_n    = state;
    baud_cnt_n = '0;
    bit_cnt_n  = bit_cnt;
    byte_idx_n = byte_idx;
    tx         = 1'b1;
    case (state)
      IDLE: begin
        bit_cnt_n  = '0;
        byte_idx_n = 1'b0;
        if (send) state_n = START;
      end
      START: begin
        tx = 1'b0;
        if (baud_tc) state_n = DATA;
      end
      DATA: begin
        tx = cur_byte[bit_cnt];
        if (baud_tc) begin
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (baud_tc) begin
          // byte1 start bit follows byte0 stop bit with no idle gap
          if (byte_idx) begin
            state_n    = IDLE;
            byte_idx_n = 1'b0;
          end else begin
            state_n    = START;
            byte_idx_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (state != IDLE && !baud_tc) baud_cnt_n = baud_cnt + CW'(1);
  end

  assign busy    = (state != IDLE);
  assign overrun = busy && send && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= 1'b0;
      range_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_cnt  <= bit_cnt_n;
      byte_idx <= byte_idx_n;
      if (accept) begin
        range_q <= range;
        err_q   <= debug_error;
      end
    end
  end

endmodule

// File: tb/tb_range_uart_tx.sv
// Self-checking bench for range_uart_tx against a bit-list model of the report.
module tb_range_uart_tx;
  localparam int C = 4;
  localparam int REPORT = 20 * C;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] range;
  logic       debug_error;
  logic       send;
  logic       tx, busy, overrun;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_q[$];

  range_uart_tx #(.WIDTH(10), .CLKS_PER_BIT(C)) dut (
    .clock(clock), .reset(reset), .range(range), .debug_error(debug_error),
    .send(send), .tx(tx), .busy(busy), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic build_expected(input logic [9:0] r, input logic e);
    logic [7:0] bytes [2];
    exp_q.delete();
    bytes[0] = {1'b1, e, 4'b0000, r[9:8]};
    bytes[1] = r[7:0];
    for (int b = 0; b < 2; b++) begin
      logic bits [10];
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = bytes[b][i];
      bits[9] = 1'b1;
      for (int i = 0; i < 10; i++)
        for (int k = 0; k < C; k++) exp_q.push_back(bits[i]);
    end
  endtask

  task automatic check_line(input string name, input int cyc, input logic etx,
                            input logic ebusy, input logic eovr);
    n_checks++;
    if (tx !== etx || busy !== ebusy || overrun !== eovr) begin
      n_fail++;
      $display("FAIL %s cyc=%0d tx/busy/overrun=%b%b%b expected %b%b%b",
               name, cyc, tx, busy, overrun, etx, ebusy, eovr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; send = 1'b1; range = 10'h155; debug_error = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state tx/busy/overrun=%b%b%b expected 100", tx, busy, overrun);
    end
    @(posedge clock); #1;
    reset = 1'b0; send = 1'b0;
    @(negedge clock);
    check_line("reset_idle", 0, 1'b1, 1'b0, 1'b0);
  endtask

  // One report; optional mid-report send pulse and range scrambling while busy.
  task automatic test_report(input string name, input logic [9:0] r, input logic e,
                             input int disturb, input bit scramble);
    build_expected(r, e);
    @(posedge clock); #1;
    range = r; debug_error = e; send = 1'b1;
    @(negedge clock);
    check_line({name, "_accept"}, -1, 1'b1, 1'b0, 1'b0);
    @(posedge clock); #1;
    send = 1'b0;
    for (int k = 0; k < REPORT; k++) begin
      send = (k == disturb);
      if (scramble) begin
        range = 10'($urandom);
        debug_error = 1'($urandom);
      end
      @(negedge clock);
      check_line(name, k, exp_q[k], 1'b1, k == disturb);
      @(posedge clock); #1;
    end
    send = 1'b0;
    @(negedge clock);
    check_line({name, "_end"}, REPORT, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [9:0] r;
    r = 10'($urandom);
    build_expected(r, 1'b0);
    @(posedge clock); #1;
    range = r; debug_error = 1'b0; send = 1'b1;
    for (int j = 0; j < 200; j++) begin
      int m;
      @(negedge clock);
      m = (j == 0) ? REPORT : (j - 1) % (REPORT + 1);
      if (m < REPORT) check_line("held", j, exp_q[m], 1'b1, 1'b1);
      else            check_line("held", j, 1'b1, 1'b0, 1'b0);
      @(posedge clock); #1;
    end
    send = 1'b0; reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    int target;
    logic [9:0] r;
    r = 10'($urandom);
    target = (10 + 1 + 3) * C + 1;
    build_expected(r, 1'b1);
    @(posedge clock); #1;
    range = r; debug_error = 1'b1; send = 1'b1;
    @(posedge clock); #1;
    send = 1'b0;
    for (int k = 0; k <= target; k++) begin
      if (k == target) begin
        reset = 1'b1; send = 1'b1;
      end
      @(negedge clock);
      if (k < target) check_line("pre_reset", k, exp_q[k], 1'b1, 1'b0);
      else begin
        n_checks++;
        if (overrun !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_overrun overrun=%b expected 0", overrun);
        end
      end
      @(posedge clock); #1;
    end
    reset = 1'b0; send = 1'b0;
    @(negedge clock);
    check_line("post_reset", 0, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    check_line("post_reset_idle", 1, 1'b1, 1'b0, 1'b0);
    test_report("after_reset", 10'h001, 1'b0, -1, 1'b0);
  endtask

  initial begin
    reset = 1'b0; send = 1'b0; range = '0; debug_error = 1'b0;
    test_reset();
    test_report("r2a5", 10'h2A5, 1'b0, -1, 1'b0);
    test_report("r3ff_err", 10'h3FF, 1'b1, -1, 1'b0);
    test_report("overrun", 10'h2A5, 1'b0, 10, 1'b0);
    test_report("scramble", 10'($urandom), 1'($urandom), -1, 1'b1);
    for (int i = 0; i < 3; i++)
      test_report("random", 10'($urandom), 1'($urandom), int'($urandom_range(REPORT - 1, 0)), 1'b1);
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
